// File: rtl/fp36_pack.sv
// Packs the FADD internal result (sign, signed exponent, 36-bit fraction) into binary32 with
// round-to-nearest-even, through a 3-stage valid/ready pipeline that collapses bubbles.
module fp36_pack #(
  parameter int unsigned FRAC_WIDTH = 36,
  parameter int unsigned EXP_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic                  i_sign,
  input  logic [EXP_WIDTH-1:0]  i_exp,
  input  logic [FRAC_WIDTH-1:0] i_frac,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [31:0]           o_data,
  output logic [3:0]            o_flags
);

  logic r_v1, r_v2, r_v3;
  logic w_rdy1, w_rdy2, w_rdy3;

  logic                  r_s1_sign;
  logic [EXP_WIDTH-1:0]  r_s1_exp;
  logic [FRAC_WIDTH-1:0] r_s1_frac;

  logic        r_s2_sign;
  logic        r_s2_zero;
  logic [34:0] r_s2_m;
  logic [9:0]  r_s2_be;

  logic [31:0] r_data;
  logic [3:0]  r_flags;

  logic [5:0]  w_lz;
  logic [34:0] w_m;
  logic [9:0]  w_be;
  logic        w_g, w_s, w_rnd;
  logic [23:0] w_fsum;
  logic [9:0]  w_be_r;
  logic [31:0] w_data;
  logic [3:0]  w_flags;

  assign w_rdy3      = ~r_v3 | i_out_ready;
  assign w_rdy2      = ~r_v2 | w_rdy3;
  assign w_rdy1      = ~r_v1 | w_rdy2;
  assign o_in_ready  = w_rdy1;
  assign o_out_valid = r_v3;
  assign o_data      = r_data;
  assign o_flags     = r_flags;

  // Ascending scan: the last hit is the highest set bit, giving the leading-zero count.
  always_comb begin
    w_lz = '0;
    for (int i = 0; i < FRAC_WIDTH; i++) begin
      if (r_s1_frac[i]) w_lz = 6'(FRAC_WIDTH - 1 - i);
    end
  end

  // The hidden bit m[35] is implied by normalization and is not carried forward.
  assign w_m  = 35'(r_s1_frac << w_lz);
  assign w_be = {{2{r_s1_exp[EXP_WIDTH-1]}}, r_s1_exp} - {4'd0, w_lz} + 10'd127;

  assign w_g    = r_s2_m[11];
  assign w_s    = |r_s2_m[10:0];
  assign w_rnd  = w_g & (w_s | r_s2_m[12]);
  assign w_fsum = {1'b0, r_s2_m[34:12]} + {23'd0, w_rnd};
  assign w_be_r = r_s2_be + {9'd0, w_fsum[23]};

  always_comb begin
    w_data  = {r_s2_sign, 31'd0};
    w_flags = 4'b0001;
    if (r_s2_zero) begin
      w_flags = 4'b0001;
    end else if ($signed(r_s2_be) < 10'sd1) begin
      w_flags = 4'b0111;
    end else if (w_be_r == 10'd255) begin
      w_data  = {r_s2_sign, 8'hFF, 23'd0};
      w_flags = 4'b1010;
    end else begin
      w_data  = {r_s2_sign, w_be_r[7:0], w_fsum[22:0]};
      w_flags = {2'b00, w_g | w_s, 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_data  <= '0;
      r_flags <= '0;
    end else begin
      if (w_rdy1) r_v1 <= i_in_valid;
      if (w_rdy2) r_v2 <= r_v1;
      if (w_rdy3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_data  <= w_data;
          r_flags <= w_flags;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_rdy1 && i_in_valid) begin
      r_s1_sign <= i_sign;
      r_s1_exp  <= i_exp;
      r_s1_frac <= i_frac;
    end
    if (w_rdy2 && r_v1) begin
      r_s2_sign <= r_s1_sign;
      r_s2_zero <= (r_s1_frac == '0);
      r_s2_m    <= w_m;
      r_s2_be   <= w_be;
    end
  end

endmodule

// File: tb/tb_fp36_pack.sv
// Randomized and directed bench for fp36_pack; expected results come from an arithmetic
// binary32 rounding model and a FIFO scoreboard of accepted operands.
module tb_fp36_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [7:0]  exp_in;
  logic [35:0] frac;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  logic [44:0] src_q[$];
  logic [35:0] exp_q[$];
  int          accepted;
  logic        held_valid;
  logic [35:0] held;

  fp36_pack #(.FRAC_WIDTH(36), .EXP_WIDTH(8)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_sign     (sign),
    .i_exp      (exp_in),
    .i_frac     (frac),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_data     (data),
    .o_flags    (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Value = frac * 2^(exp-35); take a 24-bit significand from the top set bit and round RNE.
  function automatic logic [35:0] model(input logic s, input logic [7:0] ex, input logic [35:0] fr);
    int p;
    int be;
    longint unsigned frl, sig, rem, half;
    logic inex;
    if (fr == 36'd0) return {s, 31'd0, 4'b0001};
    p = 35;
    while (!fr[p]) p--;
    be = int'($signed(ex)) - 35 + p + 127;
    if (be <= 0) return {s, 31'd0, 4'b0111};
    frl = 64'(fr);
    if (p > 23) begin
      sig  = frl >> (p - 23);
      rem  = frl & ((64'd1 << (p - 23)) - 64'd1);
      half = 64'd1 << (p - 24);
      if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
    end else begin
      sig  = frl << (23 - p);
      rem  = 0;
    end
    inex = (rem != 0);
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      be  = be + 1;
    end
    if (be >= 255) return {s, 8'hFF, 23'd0, 4'b1010};
    return {s, 8'(be), sig[22:0], 2'b00, inex, 1'b0};
  endfunction

  function automatic logic [44:0] rand_item();
    logic [35:0] fr;
    logic [7:0]  ex;
    fr = 36'({$urandom, $urandom}) >> $urandom_range(0, 35);
    if ($urandom_range(0, 15) == 0) fr = '0;
    if ($urandom_range(0, 1) == 0) ex = 8'($urandom_range(0, 80) - 40);
    else ex = 8'($urandom);
    return {1'($urandom), ex, fr};
  endfunction

  // One cycle of streaming: drive at the falling edge, settle, then score the coming transfers.
  task automatic step(input bit offer, input bit rdy);
    logic [35:0] e;
    @(negedge clk);
    in_valid  = offer && (src_q.size() > 0);
    out_ready = rdy;
    if (src_q.size() > 0) {sign, exp_in, frac} = src_q[0];
    #1;
    if (held_valid) check("stall_stable", {data, flags}, held);
    if (in_valid && in_ready) begin
      exp_q.push_back(model(sign, exp_in, frac));
      void'(src_q.pop_front());
      accepted++;
    end
    held_valid = 1'b0;
    if (out_valid) begin
      if (out_ready) begin
        check("out_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("stream_result", {data, flags}, e);
        end
      end else begin
        held       = {data, flags};
        held_valid = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  task automatic run_one(input logic s, input logic [7:0] ex, input logic [35:0] fr,
                         input logic [35:0] expv);
    int lat;
    check("model_ref", model(s, ex, fr), expv);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    {sign, exp_in, frac} = {s, ex, fr};
    #1;
    check("dir_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("dir_latency", lat, 3);
    check("dir_result", {data, flags}, expv);
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sign = 1'b0; exp_in = '0; frac = '0;
    held_valid = 1'b0; accepted = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_data", data, 0);
    check("rst_flags", flags, 0);

    run_one(1'b0, 8'd0,   36'h8_0000_0000, {32'h3F80_0000, 4'b0000});
    run_one(1'b0, 8'd35,  36'h0_0000_0001, {32'h3F80_0000, 4'b0000});
    run_one(1'b1, 8'd0,   36'h0_0000_0000, {32'h8000_0000, 4'b0001});
    run_one(1'b0, 8'd0,   36'h8_0000_0800, {32'h3F80_0000, 4'b0010});
    run_one(1'b0, 8'd0,   36'h8_0000_1800, {32'h3F80_0002, 4'b0010});
    run_one(1'b0, 8'd127, 36'hF_FFFF_FFFF, {32'h7F80_0000, 4'b1010});
    run_one(1'b1, 8'h81,  36'h8_0000_0000, {32'h8000_0000, 4'b0111});

    // Backpressure: five offered while the sink is stalled.
    for (int i = 0; i < 5; i++) src_q.push_back(rand_item());
    accepted = 0;
    repeat (6) step(1'b1, 1'b0);
    check("bp_accepted", accepted, 3);
    #2;
    check("bp_in_ready", in_ready, 0);
    for (int c = 0; c < 30 && (src_q.size() + exp_q.size()) != 0; c++) step(1'b1, 1'b1);
    check("bp_drain", src_q.size() + exp_q.size(), 0);
    check("bp_total", accepted, 5);

    // Random valid/ready toggling.
    for (int i = 0; i < 300; i++) src_q.push_back(rand_item());
    for (int c = 0; c < 4000 && (src_q.size() + exp_q.size()) != 0; c++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    check("rand_drain", src_q.size() + exp_q.size(), 0);

    // Reset with three operands in flight.
    for (int i = 0; i < 3; i++) src_q.push_back(rand_item());
    accepted = 0;
    repeat (3) step(1'b1, 1'b0);
    check("rst_fill", accepted, 3);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    src_q.delete();
    held_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1);
      #1;
      check("no_stale", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
